pipeline_hazard_ctrl: RTL
=========================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter STARTUP_BUBBLES, default 4: number of bubble cycles issued after reset while the pipeline fills.
REQ-002 SHALL have parameter CNT_W, default 16: width of the event counters.
REQ-003 SHALL have the following ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  the instruction in ID reads rs1 / rs2.
- ex_rd  in  5  destination register in EX.
- ex_reg_write  in  1  EX instruction writes a register.
- ex_mem_read  in  1  EX instruction is a load.
- mem_rd  in  5  destination register in MEM.
- mem_reg_write  in  1  MEM instruction writes a register.
- wb_rd  in  5  destination register in WB.
- wb_reg_write  in  1  WB instruction writes a register.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- halt_req  in  1  request to freeze the pipeline.
- pc_write  out  1  PC register enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  zero IF/ID on the next edge.
- idex_bubble  out  1  drives the ID/EX control mux flag; 1 inserts zero control (bubble).
- fwd_a, fwd_b  out  2 each  ALU operand mux select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
- halted  out  1  block is in HALT.
- stall_count, flush_count  out  CNT_W each  saturating event counters.

Function
REQ-004 SHALL implement FSM states INIT, RUN and HALT.
REQ-005 INIT: SHALL hold idex_bubble=1, pc_write=1, ifid_write=1 and ifid_flush=0 for exactly STARTUP_BUBBLES cycles, then go to RUN.
REQ-006 A STARTUP_BUBBLES value of 0 SHALL enter RUN on the first cycle after reset.
REQ-007 Load-use hazard = ex_mem_read & ex_reg_write & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)), evaluated combinationally.
REQ-008 RUN, load-use and no taken branch: SHALL drive pc_write=0, ifid_write=0, idex_bubble=1 in that same cycle, and increment stall_count.
REQ-009 RUN, ex_branch_taken=1: SHALL drive ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1, and increment flush_count.
REQ-010 A taken branch SHALL take priority over a simultaneous load-use hazard; that cycle counts as a flush only.
REQ-011 RUN, no hazard: SHALL drive pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
REQ-012 RUN, halt_req=1: SHALL transition to HALT on the next edge; branch and stall outputs still apply in the request cycle.
REQ-013 HALT: SHALL drive pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0 and halted=1, and remain in HALT until reset; halt_req is ignored there.
REQ-014 halt_req asserted during INIT SHALL be ignored.
REQ-015 Forwarding, operand A, in all states (combinational):
- fwd_a=10 if mem_reg_write & mem_rd!=0 & mem_rd==id_rs1;
- else fwd_a=01 if wb_reg_write & wb_rd!=0 & wb_rd==id_rs1;
- else fwd_a=00.
REQ-016 Operand B forwarding SHALL follow REQ-015 identically, using id_rs2 to drive fwd_b.
REQ-017 Register x0 SHALL never cause a stall or a forward.
REQ-018 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-019 Counters SHALL not count in INIT or HALT.

Reset
REQ-020 rst_n=0 at a rising edge SHALL force state=INIT, the startup counter=0, stall_count=0, flush_count=0 and halted=0, including mid-stall and in HALT.
REQ-021 While rst_n=0, outputs SHALL follow INIT values: idex_bubble=1, pc_write=1, ifid_write=1, ifid_flush=0.

Structure
REQ-022 A shared package/header SHALL hold the state encodings (INIT=2'd0, RUN=2'd1, HALT=2'd2) and the forwarding-select constants FWD_RF, FWD_EXMEM and FWD_MEMWB.
REQ-023 Forwarding logic SHALL be a sub-module, fwd_select, instantiated twice (operands A and B).
REQ-024 Only the FSM state, startup counter and event counters SHALL be registered; all other outputs are combinational.

Verification
REQ-025 Reset, STARTUP_BUBBLES=4 -> idex_bubble=1 for cycles 1-4, 0 on cycle 5; halted=0; both counters 0.
REQ-026 RUN, ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> same cycle pc_write=0, ifid_write=0, idex_bubble=1; stall_count 0->1.
REQ-027 Same-cycle load-use and ex_branch_taken=1 -> ifid_flush=1, pc_write=1; flush_count=1, stall_count unchanged.
REQ-028 mem_rd=3 and wb_rd=3, both writing, id_rs1=3 -> fwd_a=10; with mem_rd=0 and wb_rd=0 and id_rs1=0 -> fwd_a=00, no stall.
REQ-029 halt_req pulse in RUN -> halted=1 next cycle and pc_write=0 thereafter; rst_n=0 for one edge -> INIT, counters 0.
REQ-030 CNT_W=2 with 5 consecutive stalls -> stall_count holds at 3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and forwarding selects.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;
  localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// ALU operand forwarding select for one source register; the youngest producer wins.
module fwd_select
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic             i_mem_reg_write,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic             i_wb_reg_write,
  output logic [FWD_W-1:0] o_sel
);

  // MEM result takes precedence over WB; x0 never forwards
  always_comb begin
    o_sel = FWD_RF;
    if (i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == i_rs)) begin
      o_sel = FWD_EXMEM;
    end else if (i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == i_rs)) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: startup bubbles, load-use stalls, branch flushes,
// halt, operand forwarding and saturating stall/flush event counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned STARTUP_BUBBLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  input  logic             ex_branch_taken,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned       BOOT_W    = (STARTUP_BUBBLES > 1) ? $clog2(STARTUP_BUBBLES) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(STARTUP_BUBBLES - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [BOOT_W-1:0] r_boot_cnt;
  logic [BOOT_W-1:0] w_boot_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              w_load_use;
  logic              w_run;
  logic              w_stall_evt;
  logic              w_flush_evt;

  // Load-use: a load in EX produces a register the ID instruction needs now
  assign w_load_use = ex_mem_read & ex_reg_write & (ex_rd != '0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // With no startup bubbles the INIT cycle after reset already behaves as RUN
  assign w_run = (r_state == ST_RUN) || ((r_state == ST_INIT) && (STARTUP_BUBBLES == 0));

  // Next state and pipeline control; defaults are the INIT/reset values
  always_comb begin
    w_state_nxt = r_state;
    w_boot_nxt  = r_boot_cnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b1;
    halted      = 1'b0;
    w_stall_evt = 1'b0;
    w_flush_evt = 1'b0;
    if (rst_n) begin
      if (w_run) begin
        if (ex_branch_taken) begin
          ifid_flush  = 1'b1;
          w_flush_evt = 1'b1;
        end else if (w_load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          w_stall_evt = 1'b1;
        end else begin
          idex_bubble = 1'b0;
        end
        w_state_nxt = halt_req ? ST_HALT : ST_RUN;
      end else if (r_state == ST_INIT) begin
        if (r_boot_cnt == BOOT_LAST) begin
          w_state_nxt = ST_RUN;
          w_boot_nxt  = '0;
        end else begin
          w_boot_nxt = r_boot_cnt + 1'b1;
        end
      end else begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        halted      = 1'b1;
        w_state_nxt = ST_HALT;
      end
    end
  end

  // FSM state and startup counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_boot_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_boot_cnt <= w_boot_nxt;
    end
  end

  // Saturating stall/flush event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_evt && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;

  fwd_select u_fwd_a (
    .i_rs           (id_rs1),
    .i_mem_rd       (mem_rd),
    .i_mem_reg_write(mem_reg_write),
    .i_wb_rd        (wb_rd),
    .i_wb_reg_write (wb_reg_write),
    .o_sel          (fwd_a)
  );

  fwd_select u_fwd_b (
    .i_rs           (id_rs2),
    .i_mem_rd       (mem_rd),
    .i_mem_reg_write(mem_reg_write),
    .i_wb_rd        (wb_rd),
    .i_wb_reg_write (wb_reg_write),
    .o_sel          (fwd_b)
  );

endmodule
